// File: rtl/bcd_down_counter3_pkg.sv
// Shared definitions for the three-digit BCD down counter: FSM encoding,
// digit limits and the load-time digit clamp.
package bcd_down_counter3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int          DIGITS        = 3;
    localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
    localparam logic [11:0] BCD_ZERO      = 12'd0;

    // Any digit above 9 is replaced by 9 so the counter never holds a non-BCD digit.
    function automatic logic [4*DIGITS-1:0] clamp_bcd(input logic [4*DIGITS-1:0] value);
        logic [4*DIGITS-1:0] result;
        result = value;
        for (int i = 0; i < DIGITS; i++) begin
            if (value[4*i +: 4] > BCD_MAX_DIGIT) begin
                result[4*i +: 4] = BCD_MAX_DIGIT;
            end else begin
                result[4*i +: 4] = value[4*i +: 4];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_down_counter3_dec.sv
// One BCD digit of the decrement chain: subtracts the incoming borrow,
// wrapping 0 to 9 and passing a borrow on to the next digit.
module bcd_decrementer
    import bcd_down_counter3_pkg::*;
(
    input  logic [3:0] digit_in,
    input  logic       borrow_in,
    output logic [3:0] digit_out,
    output logic       borrow_out
);

    // Digit decrement with borrow generation
    always_comb begin
        digit_out  = digit_in;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit_in == 4'd0) begin
                digit_out  = BCD_MAX_DIGIT;
                borrow_out = 1'b1;
            end else begin
                digit_out  = digit_in - 4'd1;
                borrow_out = 1'b0;
            end
        end else begin
            digit_out  = digit_in;
            borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_down_counter3.sv
// Three-digit BCD down counter with start/stop control, optional 000->999
// wrap, a busy flag and a one-cycle done pulse.
module bcd_down_counter3
    import bcd_down_counter3_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        tick,
    input  logic [11:0] load_val,
    output logic [11:0] count,
    output logic        busy,
    output logic        done
);

    state_t              state_r;
    state_t              next_state_s;
    logic [4*DIGITS-1:0] count_r;
    logic [4*DIGITS-1:0] next_count_s;
    logic [4*DIGITS-1:0] dec_count_s;
    logic [4*DIGITS-1:0] loaded_s;
    logic [DIGITS:0]     borrow_s;
    logic                wrap_s;
    logic                busy_r;
    logic                done_r;

    assign loaded_s    = clamp_bcd(load_val);
    assign borrow_s[0] = tick;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_decrementer u_dec (
            .digit_in  (count_r[4*g +: 4]),
            .borrow_in (borrow_s[g]),
            .digit_out (dec_count_s[4*g +: 4]),
            .borrow_out(borrow_s[g+1])
        );
    end

    // Next-state and next-count selection with stop > start > tick priority
    always_comb begin
        next_state_s = state_r;
        next_count_s = count_r;
        wrap_s       = 1'b0;
        if (stop) begin
            next_state_s = IDLE;
        end else if (start) begin
            next_count_s = loaded_s;
            if ((loaded_s == BCD_ZERO) && (WRAP == 1'b0)) begin
                next_state_s = DONE;
            end else begin
                next_state_s = COUNT;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    next_state_s = IDLE;
                end
                COUNT: begin
                    if (tick) begin
                        // A borrow out of the hundreds digit means the tick hit 000.
                        if (borrow_s[DIGITS]) begin
                            if (WRAP == 1'b1) begin
                                next_count_s = dec_count_s;
                                wrap_s       = 1'b1;
                            end else begin
                                next_state_s = DONE;
                            end
                        end else begin
                            next_count_s = dec_count_s;
                            if ((dec_count_s == BCD_ZERO) && (WRAP == 1'b0)) begin
                                next_state_s = DONE;
                            end else begin
                                next_state_s = COUNT;
                            end
                        end
                    end else begin
                        next_state_s = COUNT;
                    end
                end
                DONE: begin
                    next_state_s = IDLE;
                end
                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end
    end

    // State, count and registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= BCD_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            count_r <= next_count_s;
            busy_r  <= (next_state_s == COUNT);
            done_r  <= (next_state_s == DONE) || wrap_s;
        end
    end

    assign count = count_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_bcd_down_counter3.sv
// Bench for bcd_down_counter3: a WRAP=0 and a WRAP=1 instance share stimulus,
// an integer-valued model is compared every cycle, plus directed literal checks.
module tb_bcd_down_counter3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        tick = 1'b0;
    logic [11:0] load_val = 12'd0;
    logic [11:0] count0, count1;
    logic        busy0, busy1, done0, done1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per instance: index 0 = WRAP 0, index 1 = WRAP 1
    int m_val  [2];
    bit m_busy [2];
    bit m_done [2];

    always #5 clk = ~clk;

    bcd_down_counter3 #(.WRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .tick(tick),
        .load_val(load_val), .count(count0), .busy(busy0), .done(done0)
    );

    bcd_down_counter3 #(.WRAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .tick(tick),
        .load_val(load_val), .count(count1), .busy(busy1), .done(done1)
    );

    function automatic int bcd_load_value(input logic [11:0] v);
        int h, t, o;
        h = int'(v[11:8]); t = int'(v[7:4]); o = int'(v[3:0]);
        if (h > 9) h = 9;
        if (t > 9) t = 9;
        if (o > 9) o = 9;
        return h * 100 + t * 10 + o;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: decimal value plus busy/done flags
    always @(posedge clk or posedge reset) begin
        for (int w = 0; w < 2; w++) begin
            if (reset) begin
                m_val[w]  <= 0;
                m_busy[w] <= 1'b0;
                m_done[w] <= 1'b0;
            end else if (stop) begin
                m_busy[w] <= 1'b0;
                m_done[w] <= 1'b0;
            end else if (start) begin
                m_val[w] <= bcd_load_value(load_val);
                if (bcd_load_value(load_val) == 0 && w == 0) begin
                    m_busy[w] <= 1'b0;
                    m_done[w] <= 1'b1;
                end else begin
                    m_busy[w] <= 1'b1;
                    m_done[w] <= 1'b0;
                end
            end else if (m_busy[w] && tick) begin
                if (m_val[w] == 0) begin
                    m_val[w]  <= (w == 1) ? 999 : 0;
                    m_busy[w] <= (w == 1);
                    m_done[w] <= 1'b1;
                end else if (m_val[w] == 1 && w == 0) begin
                    m_val[w]  <= 0;
                    m_busy[w] <= 1'b0;
                    m_done[w] <= 1'b1;
                end else begin
                    m_val[w]  <= m_val[w] - 1;
                    m_done[w] <= 1'b0;
                end
            end else begin
                m_done[w] <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("model count w0", count0, to_bcd(m_val[0]));
        chk("model busy w0", {11'd0, busy0}, {11'd0, m_busy[0]});
        chk("model done w0", {11'd0, done0}, {11'd0, m_done[0]});
        chk("model count w1", count1, to_bcd(m_val[1]));
        chk("model busy w1", {11'd0, busy1}, {11'd0, m_busy[1]});
        chk("model done w1", {11'd0, done1}, {11'd0, m_done[1]});
    end

    // Apply one cycle of inputs, then return 1 time unit after the edge
    task automatic step(input logic s, input logic p, input logic t, input logic [11:0] lv);
        start = s; stop = p; tick = t; load_val = lv;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; tick = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset count", count0, 12'h000);
        chk("reset busy", {11'd0, busy0}, 12'd0);
        reset = 1'b0;

        // Reset in the middle of a count at 437
        step(1'b1, 1'b0, 1'b0, 12'h437);
        step(1'b0, 1'b0, 1'b0, 12'h000);
        chk("load 437", count0, 12'h437);
        chk("busy at 437", {11'd0, busy0}, 12'd1);
        #2 reset = 1'b1;
        #1;
        chk("async reset count", count0, 12'h000);
        chk("async reset busy", {11'd0, busy0}, 12'd0);
        chk("async reset done", {11'd0, done0}, 12'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Borrow chain from 100
        step(1'b1, 1'b0, 1'b0, 12'h100);
        chk("resume after reset", count0, 12'h100);
        step(1'b0, 1'b0, 1'b1, 12'h000);
        chk("borrow 100->099", count0, 12'h099);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, 12'h000);
        chk("w0 stops at 000", count0, 12'h000);
        chk("w0 idle after done", {11'd0, busy0}, 12'd0);
        chk("w1 wrapped to 999", count1, 12'h999);
        chk("w1 wrap done", {11'd0, done1}, 12'd1);

        // Terminal count from 002
        step(1'b1, 1'b0, 1'b0, 12'h002);
        step(1'b0, 1'b0, 1'b1, 12'h000);
        chk("002->001", count0, 12'h001);
        step(1'b0, 1'b0, 1'b1, 12'h000);
        chk("001->000", count0, 12'h000);
        chk("terminal done", {11'd0, done0}, 12'd1);
        chk("terminal busy", {11'd0, busy0}, 12'd0);
        step(1'b0, 1'b0, 1'b0, 12'h000);
        chk("done one cycle", {11'd0, done0}, 12'd0);

        // Wrap from 001
        step(1'b1, 1'b0, 1'b0, 12'h001);
        step(1'b0, 1'b0, 1'b1, 12'h000);
        chk("w1 001->000", count1, 12'h000);
        step(1'b0, 1'b0, 1'b1, 12'h000);
        chk("w1 000->999", count1, 12'h999);
        chk("w1 wrap pulse", {11'd0, done1}, 12'd1);
        chk("w1 busy on wrap", {11'd0, busy1}, 12'd1);
        step(1'b0, 1'b0, 1'b0, 12'h000);
        chk("w1 pulse ends", {11'd0, done1}, 12'd0);

        // Priority stop > start > tick
        step(1'b1, 1'b0, 1'b0, 12'h250);
        step(1'b0, 1'b0, 1'b0, 12'h000);
        step(1'b1, 1'b1, 1'b1, 12'h123);
        chk("stop wins count", count0, 12'h250);
        chk("stop wins busy", {11'd0, busy0}, 12'd0);
        step(1'b0, 1'b0, 1'b1, 12'h000);
        chk("tick ignored idle", count0, 12'h250);
        step(1'b1, 1'b0, 1'b1, 12'h123);
        chk("start beats tick", count0, 12'h123);
        chk("restart busy", {11'd0, busy0}, 12'd1);

        // Load clamping and zero start
        step(1'b1, 1'b0, 1'b0, 12'hFFF);
        chk("clamp FFF", count0, 12'h999);
        step(1'b1, 1'b0, 1'b0, 12'hA5F);
        chk("clamp A5F", count0, 12'h959);
        step(1'b1, 1'b0, 1'b0, 12'h000);
        chk("zero start done", {11'd0, done0}, 12'd1);
        chk("zero start busy", {11'd0, busy0}, 12'd0);
        chk("w1 zero start busy", {11'd0, busy1}, 12'd1);
        step(1'b1, 1'b0, 1'b0, 12'h005);
        chk("start from done", count0, 12'h005);
        chk("busy after done restart", {11'd0, busy0}, 12'd1);
        step(1'b0, 1'b1, 1'b0, 12'h000);
        step(1'b0, 1'b0, 1'b0, 12'h000);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
